// File: rtl/led_code_blinker.sv
// Turns a small numeric status code into an LED blink pattern: N flashes, then a long dark gap.
// The pattern can optionally repeat. Codes are handed over on a valid/ready handshake.
module led_code_blinker #(
    parameter int unsigned CODE_W  = 4,
    parameter logic [31:0] ON_CYC  = 32'd12_500_000,
    parameter logic [31:0] OFF_CYC = 32'd12_500_000,
    parameter logic [31:0] GAP_CYC = 32'd50_000_000,
    parameter logic        LED_POL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] code,
    input  logic              repeat_en,
    output logic              code_ready,
    output logic              led_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = 32;

    // Counter reload values; a zero-length phase is stretched to one cycle.
    localparam logic [CNT_W-1:0] ON_LD  = (ON_CYC  == 32'd0) ? 32'd0 : ON_CYC  - 32'd1;
    localparam logic [CNT_W-1:0] OFF_LD = (OFF_CYC == 32'd0) ? 32'd0 : OFF_CYC - 32'd1;
    localparam logic [CNT_W-1:0] GAP_LD = (GAP_CYC == 32'd0) ? 32'd0 : GAP_CYC - 32'd1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CODE_W-1:0] n_left, n_left_nxt;
    logic [CODE_W-1:0] code_q, code_q_nxt;
    logic              rep_q, rep_q_nxt;
    logic              led_nxt, busy_nxt, done_nxt;
    logic              cnt_zero;

    assign code_ready = (state == S_IDLE);
    assign cnt_zero   = (cnt == '0);

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            n_left  <= '0;
            code_q  <= '0;
            rep_q   <= 1'b0;
            led_out <= ~LED_POL;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            n_left  <= n_left_nxt;
            code_q  <= code_q_nxt;
            rep_q   <= rep_q_nxt;
            led_out <= led_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    // Next-state logic; outputs follow the next state so they line up with it.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        n_left_nxt = n_left;
        code_q_nxt = code_q;
        rep_q_nxt  = rep_q;
        done_nxt   = 1'b0;

        case (state)
            S_IDLE: begin
                if (code_valid) begin
                    code_q_nxt = code;
                    n_left_nxt = code;
                    rep_q_nxt  = repeat_en;
                    if (code != '0) begin
                        state_nxt = S_ON;
                        cnt_nxt   = ON_LD;
                    end else begin
                        state_nxt = S_GAP;
                        cnt_nxt   = GAP_LD;
                    end
                end
            end
            S_ON: begin
                if (!cnt_zero) begin
                    cnt_nxt = cnt - 32'd1;
                end else if (n_left > CODE_W'(1)) begin
                    state_nxt  = S_OFF;
                    cnt_nxt    = OFF_LD;
                    n_left_nxt = n_left - CODE_W'(1);
                end else begin
                    state_nxt = S_GAP;
                    cnt_nxt   = GAP_LD;
                end
            end
            S_OFF: begin
                if (!cnt_zero) begin
                    cnt_nxt = cnt - 32'd1;
                end else begin
                    state_nxt = S_ON;
                    cnt_nxt   = ON_LD;
                end
            end
            S_GAP: begin
                if (!cnt_zero) begin
                    cnt_nxt = cnt - 32'd1;
                end else if (rep_q && repeat_en) begin
                    // Repeat: code 0 just re-runs the gap.
                    n_left_nxt = code_q;
                    if (code_q != '0) begin
                        state_nxt = S_ON;
                        cnt_nxt   = ON_LD;
                    end else begin
                        cnt_nxt = GAP_LD;
                    end
                end else begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        led_nxt  = (state_nxt == S_ON) ? LED_POL : ~LED_POL;
        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_led_code_blinker.sv
// Bench for led_code_blinker: fixed vector table, directed corner sequences and
// random traffic checked against a queue-based timeline model.
module tb_led_code_blinker;

    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int GAP = 5;

    logic       clk;
    logic       rst;
    logic       code_valid;
    logic [3:0] code;
    logic       repeat_en;
    logic       code_ready;
    logic       led_out;
    logic       busy;
    logic       done;

    logic       drv_rst, drv_cv, drv_rep;
    logic [3:0] drv_code;

    int tests = 0;
    int fails = 0;

    assign rst        = drv_rst;
    assign code_valid = drv_cv;
    assign code       = drv_code;
    assign repeat_en  = drv_rep;

    led_code_blinker #(
        .CODE_W (4),
        .ON_CYC (32'd3),
        .OFF_CYC(32'd2),
        .GAP_CYC(32'd5),
        .LED_POL(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .code_valid(code_valid),
        .code      (code),
        .repeat_en (repeat_en),
        .code_ready(code_ready),
        .led_out   (led_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timeline model: a queue of LED levels for every remaining busy cycle.
    bit         mq[$];
    logic [3:0] m_code;
    bit         m_rep;
    bit         m_done;

    function automatic void build(input int n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < ON; k++) mq.push_back(1'b1);
            if (i != n - 1) for (int k = 0; k < OFF; k++) mq.push_back(1'b0);
        end
        for (int k = 0; k < GAP; k++) mq.push_back(1'b0);
    endfunction

    function automatic void model_edge();
        m_done = 1'b0;
        if (drv_rst) begin
            mq.delete();
            m_rep  = 1'b0;
            m_code = 4'd0;
        end else if (mq.size() == 0) begin
            if (drv_cv) begin
                m_code = drv_code;
                m_rep  = drv_rep;
                build(int'(drv_code));
            end
        end else begin
            void'(mq.pop_front());
            if (mq.size() == 0) begin
                if (m_rep && drv_rep) build(int'(m_code));
                else m_done = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        bit e_busy;
        e_busy = (mq.size() != 0);
        chk("model_busy",  busy,       e_busy);
        chk("model_led",   led_out,    e_busy ? mq[0] : 1'b0);
        chk("model_done",  done,       m_done);
        chk("model_ready", code_ready, !e_busy);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic stepc();
        step();
        check_model();
    endtask

    task automatic wait_done(input int max_cyc, inout int n, output bit got);
        got = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            stepc();
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (busy === 1'b1) n++;
        end
    endtask

    typedef struct {
        logic       rst;
        logic       cv;
        logic [3:0] code;
        logic       rep;
        logic       led;
        logic       busy;
        logic       done;
        logic       ready;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic [3:0] c, input logic p,
                                input logic l, input logic b, input logic d, input logic y);
        vec_t t;
        t.rst = r; t.cv = v; t.code = c; t.rep = p;
        t.led = l; t.busy = b; t.done = d; t.ready = y;
        return t;
    endfunction

    vec_t vecs[22];

    initial begin
        int  n;
        int  d;
        bit  got;

        // Reset with valid held, then code 3 accepted at edge T (entry 2); outputs are after each edge.
        vecs[0]  = mk(1, 1, 4'd3, 0,  0, 0, 0, 1);
        vecs[1]  = mk(1, 1, 4'd3, 0,  0, 0, 0, 1);
        vecs[2]  = mk(0, 1, 4'd3, 0,  1, 1, 0, 0);  // T+1
        vecs[3]  = mk(0, 0, 4'd0, 0,  1, 1, 0, 0);
        vecs[4]  = mk(0, 0, 4'd0, 0,  1, 1, 0, 0);  // T+3
        vecs[5]  = mk(0, 0, 4'd0, 0,  0, 1, 0, 0);
        vecs[6]  = mk(0, 0, 4'd0, 0,  0, 1, 0, 0);
        vecs[7]  = mk(0, 0, 4'd0, 0,  1, 1, 0, 0);  // T+6
        vecs[8]  = mk(0, 0, 4'd0, 0,  1, 1, 0, 0);
        vecs[9]  = mk(0, 0, 4'd0, 0,  1, 1, 0, 0);
        vecs[10] = mk(0, 0, 4'd0, 0,  0, 1, 0, 0);
        vecs[11] = mk(0, 0, 4'd0, 0,  0, 1, 0, 0);
        vecs[12] = mk(0, 0, 4'd0, 0,  1, 1, 0, 0);  // T+11
        vecs[13] = mk(0, 0, 4'd0, 0,  1, 1, 0, 0);
        vecs[14] = mk(0, 0, 4'd0, 0,  1, 1, 0, 0);
        vecs[15] = mk(0, 0, 4'd0, 0,  0, 1, 0, 0);  // T+14 gap
        vecs[16] = mk(0, 0, 4'd0, 0,  0, 1, 0, 0);
        vecs[17] = mk(0, 0, 4'd0, 0,  0, 1, 0, 0);
        vecs[18] = mk(0, 0, 4'd0, 0,  0, 1, 0, 0);
        vecs[19] = mk(0, 0, 4'd0, 0,  0, 1, 0, 0);  // T+18
        vecs[20] = mk(0, 0, 4'd0, 0,  0, 0, 1, 1);  // T+19 done
        vecs[21] = mk(0, 0, 4'd0, 0,  0, 0, 0, 1);

        drv_rst = 1'b1; drv_cv = 1'b0; drv_code = 4'd0; drv_rep = 1'b0;

        for (int i = 0; i < 22; i++) begin
            drv_rst  = vecs[i].rst;
            drv_cv   = vecs[i].cv;
            drv_code = vecs[i].code;
            drv_rep  = vecs[i].rep;
            step();
            chk($sformatf("vec%0d_led", i),   led_out,    vecs[i].led);
            chk($sformatf("vec%0d_busy", i),  busy,       vecs[i].busy);
            chk($sformatf("vec%0d_done", i),  done,       vecs[i].done);
            chk($sformatf("vec%0d_ready", i), code_ready, vecs[i].ready);
        end

        // Code 0, then code 15 presented in its done cycle.
        drv_cv = 1'b1; drv_code = 4'd0; drv_rep = 1'b0;
        stepc();
        n = busy ? 1 : 0;
        drv_cv = 1'b0;
        wait_done(20, n, got);
        chk_int("code0_done_seen", int'(got), 1);
        chk_int("code0_busy_cycles", n, 5);
        drv_cv = 1'b1; drv_code = 4'd15;
        stepc();
        chk("code15_first_lit", led_out, 1'b1);
        n = busy ? 1 : 0;
        drv_cv = 1'b0;
        wait_done(200, n, got);
        chk_int("code15_done_seen", int'(got), 1);
        chk_int("code15_busy_cycles", n, 78);

        // Code 2 repeating; repeat_en dropped in the first cycle of the third gap.
        drv_cv = 1'b1; drv_code = 4'd2; drv_rep = 1'b1;
        stepc();
        n = busy ? 1 : 0;
        d = 0;
        drv_cv = 1'b0;
        for (int k = 0; k < 34; k++) begin
            stepc();
            if (done === 1'b1) d++;
            if (busy === 1'b1) n++;
        end
        chk_int("rep_no_mid_done", d, 0);
        drv_rep = 1'b0;
        wait_done(50, n, got);
        chk_int("rep_done_seen", int'(got), 1);
        chk_int("rep_busy_cycles", n, 39);

        // Reset during the second flash of code 5, then code 1 right after.
        drv_cv = 1'b1; drv_code = 4'd5;
        stepc();
        drv_cv = 1'b0;
        for (int k = 0; k < 5; k++) stepc();
        chk("rst_mid_lit_before", led_out, 1'b1);
        drv_rst = 1'b1;
        stepc();
        chk("rst_mid_led",  led_out,    1'b0);
        chk("rst_mid_busy", busy,       1'b0);
        chk("rst_mid_done", done,       1'b0);
        chk("rst_mid_rdy",  code_ready, 1'b1);
        drv_rst = 1'b0; drv_cv = 1'b1; drv_code = 4'd1;
        stepc();
        chk("after_rst_accept_busy", busy, 1'b1);
        chk("after_rst_done", done, 1'b0);
        n = busy ? 1 : 0;
        drv_cv = 1'b0;
        wait_done(30, n, got);
        chk_int("after_rst_done_seen", int'(got), 1);
        chk_int("after_rst_busy_cycles", n, 8);

        // code_valid held high through a code-4 pattern.
        drv_cv = 1'b1; drv_code = 4'd4;
        stepc();
        drv_code = 4'd1;
        n = busy ? 1 : 0;
        wait_done(60, n, got);
        chk_int("held_done_seen", int'(got), 1);
        chk_int("held_busy_cycles", n, 23);
        chk("held_ready_in_done", code_ready, 1'b1);
        stepc();
        chk("held_second_accept", busy, 1'b1);
        n = busy ? 1 : 0;
        drv_cv = 1'b0;
        wait_done(30, n, got);
        chk_int("held_second_busy_cycles", n, 8);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            drv_rst  = ($urandom_range(0, 199) == 0);
            drv_cv   = ($urandom_range(0, 2) == 0);
            drv_code = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            drv_rep  = ($urandom_range(0, 9) < 7);
            stepc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
